// File: rtl/matmul_bc_feeder.sv
// Lane-0 broadcast-chain injector: buffers a run of operand words in a small
// FIFO and presents them to the broadcast chain, pulsing done/invalidate at the end.
module matmul_bc_feeder #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CntWidth-1:0]  len_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 opnd_valid_i,
  output logic                 opnd_ready_o,
  input  logic [DataWidth-1:0] opnd_data_i,
  output logic                 bc_valid_o,
  input  logic                 bc_ready_i,
  output logic [DataWidth-1:0] bc_data_o,
  output logic                 bc_invalidate_o
);

  localparam int unsigned AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  len_q, len_d;
  logic [CntWidth-1:0]  fetch_q, fetch_d;
  logic [CntWidth-1:0]  sent_q, sent_d;
  logic [AddrW:0]       wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]       rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] mem_q [FifoDepth];

  logic empty, full, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign busy_o          = (state_q == StRun);
  assign done_o          = (state_q == StDone);
  assign bc_invalidate_o = (state_q == StDone);
  assign opnd_ready_o    = busy_o && (fetch_q < len_q) && !full;
  assign bc_valid_o      = !empty;
  assign bc_data_o       = mem_q[rd_ptr_q[AddrW-1:0]];

  assign push = opnd_valid_i && opnd_ready_o && !flush_i;
  assign pop  = bc_valid_o && bc_ready_i && !flush_i;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    fetch_d  = fetch_q;
    sent_d   = sent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      state_d  = StIdle;
      fetch_d  = '0;
      sent_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fetch_d  = fetch_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        sent_d   = sent_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_d   = len_i;
            fetch_d = '0;
            sent_d  = '0;
            state_d = (len_i != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (pop && (sent_q + CntWidth'(1) == len_q)) state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      len_q    <= '0;
      fetch_q  <= '0;
      sent_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      fetch_q  <= fetch_d;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= opnd_data_i;
    end
  end

endmodule

// File: tb/tb_matmul_bc_feeder.sv
// Randomised bench for matmul_bc_feeder against a queue-based run model.
module tb_matmul_bc_feeder;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, flush = 1'b0, opnd_valid = 1'b0, bc_ready = 1'b0;
  logic [CW-1:0] len_in = '0;
  logic [DW-1:0] opnd_data = '0;
  logic busy_o, done_o, opnd_ready_o, bc_valid_o, bc_invalidate_o;
  logic [DW-1:0] bc_data_o;

  matmul_bc_feeder #(.NrLanes(4), .DataWidth(DW), .FifoDepth(DEPTH), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len_in), .flush_i(flush),
    .busy_o(busy_o), .done_o(done_o), .opnd_valid_i(opnd_valid), .opnd_ready_o(opnd_ready_o),
    .opnd_data_i(opnd_data), .bc_valid_o(bc_valid_o), .bc_ready_i(bc_ready),
    .bc_data_o(bc_data_o), .bc_invalidate_o(bc_invalidate_o)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: 0 idle, 1 running, 2 done; the FIFO is a plain queue.
  int m_phase = 0;
  logic [CW-1:0] m_len = '0, m_fetch = '0, m_sent = '0;
  logic [DW-1:0] m_fifo[$];
  bit m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_len = '0; m_fetch = '0; m_sent = '0; m_fifo.delete();
    end else if (flush) begin
      m_phase = 0; m_fetch = '0; m_sent = '0; m_fifo.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_len = len_in; m_fetch = '0; m_sent = '0;
          m_phase = (len_in != 0) ? 1 : 2;
        end
        1: begin
          m_push = opnd_valid && (m_fetch < m_len) && (m_fifo.size() < DEPTH);
          m_pop  = bc_ready && (m_fifo.size() > 0);
          if (m_pop) begin void'(m_fifo.pop_front()); m_sent++; end
          if (m_push) begin m_fifo.push_back(opnd_data); m_fetch++; end
          if (m_pop && m_sent == m_len) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) if (rst_n) begin
    chk("busy", busy_o, m_phase == 1);
    chk("done", done_o, m_phase == 2);
    chk("invalidate", bc_invalidate_o, m_phase == 2);
    chk("opnd_ready", opnd_ready_o, (m_phase == 1) && (m_fetch < m_len) && (m_fifo.size() < DEPTH));
    chk("bc_valid", bc_valid_o, m_fifo.size() > 0);
    if (m_fifo.size() > 0) chk("bc_data", bc_data_o, m_fifo[0]);
  end

  // Handshake monitor: logs accepted and broadcast words with cycle stamps.
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;
  logic [DW-1:0] acc_log[$], pop_log[$];
  int unsigned acc_cyc[$], pop_cyc[$];
  int unsigned done_cnt = 0;
  bit saw_ready = 0, saw_valid = 0, prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (opnd_valid && opnd_ready_o) begin acc_log.push_back(opnd_data); acc_cyc.push_back(cyc); end
      if (bc_valid_o && bc_ready) begin pop_log.push_back(bc_data_o); pop_cyc.push_back(cyc); end
      if (done_o) done_cnt++;
      if (opnd_ready_o) saw_ready = 1;
      if (bc_valid_o) saw_valid = 1;
      if (prev_stall && bc_valid_o) chk("stall_stable", bc_data_o, prev_data);
      prev_stall = bc_valid_o && !bc_ready;
      prev_data = bc_data_o;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); pop_log.delete(); acc_cyc.delete(); pop_cyc.delete();
    done_cnt = 0; saw_ready = 0; saw_valid = 0;
  endtask

  task automatic start_run(input int unsigned len);
    step(); start = 1'b1; len_in = CW'(len);
    step(); start = 1'b0;
  endtask

  task automatic run_phase(input int unsigned max_cyc, input int unsigned vp, input int unsigned rp,
                           input bit seq, input logic [DW-1:0] base, input bit need_done,
                           input bit stray, output bit got_done);
    got_done = 0;
    for (int unsigned c = 0; c < max_cyc && !got_done; c++) begin
      opnd_valid = (vp >= 100) ? 1'b1 : ($urandom_range(99) < vp);
      bc_ready   = (rp >= 100) ? 1'b1 : ($urandom_range(99) < rp);
      opnd_data  = seq ? base + DW'(m_fetch) : {$urandom, $urandom};
      if (stray) begin start = ($urandom_range(9) == 0); len_in = CW'($urandom); end
      @(negedge clk);
      if (done_o) got_done = 1;
      else step();
    end
    if (got_done) step();
    start = 1'b0;
    if (need_done && !got_done) chk("run_timeout", 0, 1);
  endtask

  task automatic chk_seq(input string name, input logic [DW-1:0] base, input int unsigned n);
    chk({name, "_count"}, pop_log.size(), n);
    for (int unsigned i = 0; i < pop_log.size() && i < n; i++)
      chk({name, "_word"}, pop_log[i], base + DW'(i));
  endtask

  bit gd;
  int unsigned lens[3] = '{1, 7, 300};

  initial begin
    repeat (3) step();
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_ready", opnd_ready_o, 0);
    chk("rst_valid", bc_valid_o, 0); chk("rst_inv", bc_invalidate_o, 0); chk("rst_data", bc_data_o, 0);
    rst_n = 1'b1;
    step();

    // Streaming run, both sides always ready.
    clear_logs();
    start_run(5);
    run_phase(50, 100, 100, 1, 64'h10, 1, 0, gd);
    chk("t1_accepts", acc_log.size(), 5);
    chk_seq("t1", 64'h10, 5);
    for (int unsigned i = 1; i < pop_cyc.size(); i++) chk("t1_consecutive", pop_cyc[i], pop_cyc[0] + i);
    if (pop_cyc.size() > 0 && acc_cyc.size() > 0) chk("t1_latency", pop_cyc[0], acc_cyc[0] + 1);
    chk("t1_done_pulses", done_cnt, 1);

    // Backpressure fills the FIFO, then drains in order.
    clear_logs();
    start_run(8);
    run_phase(10, 100, 0, 1, 64'h20, 0, 0, gd);
    chk("t2_accepts_stalled", acc_log.size(), DEPTH);
    chk("t2_ready_low", opnd_ready_o, 0);
    chk("t2_head_held", bc_data_o, 64'h20);
    run_phase(60, 100, 100, 1, 64'h20, 1, 0, gd);
    chk("t2_accepts", acc_log.size(), 8);
    chk_seq("t2", 64'h20, 8);

    // Zero-length run.
    clear_logs();
    opnd_valid = 1'b1; bc_ready = 1'b1;
    start_run(0);
    chk("t3_done", done_o, 1);
    chk("t3_inv", bc_invalidate_o, 1);
    step(); step();
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_no_ready", saw_ready, 0);
    chk("t3_no_valid", saw_valid, 0);
    chk("t3_no_accepts", acc_log.size(), 0);

    // Flush mid-run with one word buffered.
    clear_logs();
    start_run(6);
    opnd_valid = 1'b1; bc_ready = 1'b1; opnd_data = 64'h40 + DW'(m_fetch);
    for (int c = 0; c < 20 && pop_log.size() < 3; c++) begin step(); opnd_data = 64'h40 + DW'(m_fetch); end
    chk("t4_fetched", acc_log.size(), 4);
    flush = 1'b1; opnd_valid = 1'b0; bc_ready = 1'b0;
    step(); flush = 1'b0;
    chk("t4_busy", busy_o, 0); chk("t4_valid", bc_valid_o, 0); chk("t4_done", done_o, 0);
    step(); step();
    chk("t4_no_done", done_cnt, 0);
    clear_logs();
    start_run(2);
    run_phase(30, 100, 100, 1, 64'h50, 1, 0, gd);
    chk_seq("t4b", 64'h50, 2);

    // Random handshakes with stray starts during the run.
    foreach (lens[k]) begin
      clear_logs();
      start_run(lens[k]);
      run_phase(lens[k] * 10 + 50, 50, 50, 0, '0, 1, 1, gd);
      chk("t5_accepts", acc_log.size(), lens[k]);
      chk("t5_pops", pop_log.size(), lens[k]);
      for (int unsigned i = 0; i < pop_log.size() && i < acc_log.size(); i++) chk("t5_order", pop_log[i], acc_log[i]);
      chk("t5_done_pulses", done_cnt, 1);
      step();
    end

    // Asynchronous reset with FIFO occupied.
    clear_logs();
    start_run(8);
    opnd_valid = 1'b1; bc_ready = 1'b0; opnd_data = 64'h60;
    step(); step(); step();
    chk("t6_pre_valid", bc_valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy_o, 0); chk("t6_done", done_o, 0); chk("t6_ready", opnd_ready_o, 0);
    chk("t6_valid", bc_valid_o, 0); chk("t6_inv", bc_invalidate_o, 0); chk("t6_data", bc_data_o, 0);
    opnd_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_busy", busy_o, 0);
    step();
    clear_logs();
    start_run(3);
    run_phase(30, 100, 100, 1, 64'h70, 1, 0, gd);
    chk_seq("t6b", 64'h70, 3);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/matmul_bc_feeder.md
# matmul_bc_feeder

Broadcast-chain injector for the matmul datapath: sits in lane 0 directly upstream of the first lane's broadcast register stage and feeds its `bc_data_i`. Accepts a run of `len_i` ELEN-wide operand words from the lane's operand queue, buffers them in a small FIFO, and presents them one per handshake to the broadcast chain. Signals run completion with `done_o` and a one-cycle invalidate pulse so downstream lanes can drop stale chain contents.

## Interface
- `NrLanes`, default 4: number of lanes in the chain; informational, sizes nothing internally.
- `DataWidth`, default 64: operand/broadcast word width (ELEN).
- `FifoDepth`, default 4: skid FIFO entries; must be a power of two, ≥2.
- `CntWidth`, default 16: width of length and element counters.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start a run; sampled only in IDLE.
- `len_i` in CntWidth: number of words in the run; sampled with `start_i`.
- `flush_i` in 1: synchronous abort; clears FIFO and counters, returns to IDLE.
- `busy_o` out 1: high in RUN.
- `done_o` out 1: one-cycle pulse at run completion.
- `opnd_valid_i` in 1: operand word valid.
- `opnd_ready_o` out 1: feeder accepts operand word.
- `opnd_data_i` in DataWidth: operand word.
- `bc_valid_o` out 1: broadcast word valid.
- `bc_ready_i` in 1: chain accepts broadcast word.
- `bc_data_o` out DataWidth: broadcast word (FIFO head).
- `bc_invalidate_o` out 1: one-cycle pulse, coincident with `done_o`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start_i`=1 loads `len_q`←`len_i`, clears `fetch_cnt`, `sent_cnt`. If `len_i`≠0 → RUN; if `len_i`=0 → DONE (no transfers).
- RUN: operand handshake (`opnd_valid_i & opnd_ready_o`) pushes word, `fetch_cnt`++. Broadcast handshake (`bc_valid_o & bc_ready_i`) pops head, `sent_cnt`++. When pop makes `sent_cnt`=`len_q` → DONE.
- DONE: one cycle; `done_o`=1, `bc_invalidate_o`=1; → IDLE.
- `opnd_ready_o` = RUN & (`fetch_cnt`<`len_q`) & FIFO not full; depends on registered state only, never on `bc_ready_i` (a full FIFO refuses push even if popping same cycle).
- `bc_valid_o` = FIFO not empty; `bc_data_o` = head entry, held stable while `bc_valid_o` & !`bc_ready_i`.
- Simultaneous push and pop in RUN: both occur; occupancy unchanged.
- `start_i` outside IDLE: ignored.
- `flush_i`: highest priority in any state; next cycle state=IDLE, FIFO empty, counters 0, no `done_o`/`bc_invalidate_o` pulse. `flush_i` with `start_i` in IDLE: flush wins, run not started.
- Counters are CntWidth unsigned; `len_i` up to 2^CntWidth−1 supported, no wrap within a run.
- FIFO pointers wrap modulo FifoDepth with an extra bit for full/empty distinction.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `opnd_ready_o`, `bc_valid_o`, `bc_invalidate_o` = 0; `bc_data_o` = 0; FIFO empty; counters 0.
- `start_i` at cycle t → `busy_o`, `opnd_ready_o` (if FIFO not full) high at t+1.
- Operand accepted at cycle t → visible on `bc_valid_o`/`bc_data_o` at t+1 (one-cycle latency through FIFO).
- Final pop at cycle t → `done_o`, `bc_invalidate_o` high at t+1 only; IDLE at t+2; new `start_i` accepted at t+2.
- `len_i`=0 start at t → `done_o` at t+1, no handshakes.
- Sustained throughput: one word/cycle with `bc_ready_i` and `opnd_valid_i` held high.

## Test plan
- Start `len_i`=5, `opnd_valid_i` and `bc_ready_i` always 1, data 0x10..0x14 -> `bc_data_o` sequence 0x10..0x14 on consecutive cycles starting one cycle after first accept; `done_o`/`bc_invalidate_o` single pulse after last pop; exactly 5 operand accepts.
- Start `len_i`=8, `bc_ready_i`=0 for 10 cycles -> exactly FifoDepth (4) accepts, `opnd_ready_o` low thereafter, `bc_data_o` holds first word; release `bc_ready_i` -> remaining 4 flow, order preserved.
- Start `len_i`=0 -> `done_o` pulse next cycle, `opnd_ready_o` and `bc_valid_o` never high.
- Flush mid-run after 3 of 6 words sent, 1 buffered -> next cycle IDLE, `bc_valid_o`=0, no `done_o`; subsequent `len_i`=2 run outputs only its own 2 words.
- Random `opnd_valid_i`/`bc_ready_i` (50%) over runs of lengths 1, 7, 300 -> scoreboard order match, no drop/duplicate, `bc_data_o` stable while stalled, `start_i` during RUN ignored.
- Assert `rst_ni` low mid-run with FIFO non-empty -> all outputs 0 immediately (asynchronous), state IDLE after release.
